// File: rtl/clock_adjust_ctrl_pkg.sv
// Shared types and widths for the clock/alarm controller and its counters.
package clock_adjust_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        ADJUST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FLD_T_HR  = 2'd0,
        FLD_T_MIN = 2'd1,
        FLD_A_HR  = 2'd2,
        FLD_A_MIN = 2'd3
    } field_t;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

endpackage

// File: rtl/clock_adjust_ctrl_wrap_counter.sv
// Modulo-MOD up/down counter with synchronous clear and carry on wrap-up.
// Latency: count updates one clk after inc/dec/clr; carry is combinational.
// Backpressure: none, every request is taken in the cycle it is presented.
module wrap_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] MAX = W'(MOD - 1);

    logic at_max;
    logic at_zero;

    assign at_max  = (cnt == MAX);
    assign at_zero = (cnt == '0);
    // Carry only on a genuine +1 that wraps, so chained counters never see a decrement wrap.
    assign carry   = inc && !dec && !clr && at_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= at_max ? '0 : cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= at_zero ? MAX : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-of-day and alarm keeper with RUN/ADJUST mode FSM driven by button pulses.
// Latency: every input acts at the next rising clk edge; all state is registered.
// Backpressure: none, inputs are level-sampled and each high cycle is one event.
module clock_adjust_ctrl
    import clock_adjust_ctrl_pkg::*;
#(
    parameter int HR_MOD  = 24,
    parameter int MIN_MOD = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             center,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [MIN_W-1:0] seconds,
    output logic [HR_W-1:0]  alarm_hours,
    output logic [MIN_W-1:0] alarm_minutes,
    output logic             adjusting,
    output logic [1:0]       sel_field,
    output logic             alarm_armed,
    output logic             alarm_ringing
);

    state_t     state, state_nxt;
    logic [1:0] sel_nxt;
    logic       armed_nxt;
    logic       ring_nxt;

    logic       run_tick;
    logic       sec_clr;
    logic [3:0] adj_inc;
    logic [3:0] adj_dec;

    logic       sec_carry;
    logic       min_carry;
    logic       hr_carry;
    logic       ahr_carry;
    logic       amin_carry;

    logic             sec_wrap;
    logic             min_wrap;
    logic [MIN_W-1:0] next_min;
    logic [HR_W-1:0]  next_hr;
    logic             alarm_hit;

    // Time the clock will show after this tick; the alarm compares against it.
    assign sec_wrap  = (seconds == MIN_W'(MIN_MOD - 1));
    assign min_wrap  = (minutes == MIN_W'(MIN_MOD - 1));
    assign next_min  = !sec_wrap ? minutes : (min_wrap ? '0 : minutes + 1'b1);
    assign next_hr   = !(sec_wrap && min_wrap) ? hours
                     : ((hours == HR_W'(HR_MOD - 1)) ? '0 : hours + 1'b1);
    assign alarm_hit = sec_wrap && (next_min == alarm_minutes) && (next_hr == alarm_hours);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_field;
        armed_nxt = alarm_armed;
        ring_nxt  = alarm_ringing;
        run_tick  = 1'b0;
        sec_clr   = 1'b0;
        adj_inc   = '0;
        adj_dec   = '0;
        case (state)
            RUN: begin
                run_tick = tick_1hz;
                if (center) begin
                    if (alarm_ringing) begin
                        ring_nxt = 1'b0;
                    end else begin
                        state_nxt = ADJUST;
                        sel_nxt   = FLD_T_HR;
                    end
                end else if (up) begin
                    armed_nxt = !alarm_armed;
                    if (alarm_armed) begin
                        ring_nxt = 1'b0;
                    end
                end
                // A button that clears or disarms in the same cycle wins over a new match.
                if (tick_1hz && alarm_hit && alarm_armed && !alarm_ringing && !center && !up) begin
                    ring_nxt = 1'b1;
                end
            end
            ADJUST: begin
                if (center) begin
                    state_nxt = RUN;
                    sec_clr   = 1'b1;
                end else if (left || right) begin
                    if (right && !left) begin
                        sel_nxt = sel_field + 2'd1;
                    end else if (left && !right) begin
                        sel_nxt = sel_field - 2'd1;
                    end
                end else if (up != down) begin
                    adj_inc[sel_field] = up;
                    adj_dec[sel_field] = down;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            sel_field     <= FLD_T_HR;
            alarm_armed   <= 1'b0;
            alarm_ringing <= 1'b0;
        end else begin
            state         <= state_nxt;
            sel_field     <= sel_nxt;
            alarm_armed   <= armed_nxt;
            alarm_ringing <= ring_nxt;
        end
    end

    assign adjusting = (state == ADJUST);

    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_tick),
        .dec   (1'b0),
        .clr   (sec_clr),
        .cnt   (seconds),
        .carry (sec_carry)
    );

    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_carry || adj_inc[FLD_T_MIN]),
        .dec   (adj_dec[FLD_T_MIN]),
        .clr   (1'b0),
        .cnt   (minutes),
        .carry (min_carry)
    );

    // Minute wraps made by hand in ADJUST must not bump the hour.
    wrap_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   ((run_tick && min_carry) || adj_inc[FLD_T_HR]),
        .dec   (adj_dec[FLD_T_HR]),
        .clr   (1'b0),
        .cnt   (hours),
        .carry (hr_carry)
    );

    wrap_counter #(.MOD(HR_MOD), .W(HR_W)) u_alarm_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (adj_inc[FLD_A_HR]),
        .dec   (adj_dec[FLD_A_HR]),
        .clr   (1'b0),
        .cnt   (alarm_hours),
        .carry (ahr_carry)
    );

    wrap_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_alarm_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (adj_inc[FLD_A_MIN]),
        .dec   (adj_dec[FLD_A_MIN]),
        .clr   (1'b0),
        .cnt   (alarm_minutes),
        .carry (amin_carry)
    );

    logic unused_carry;
    assign unused_carry = hr_carry ^ ahr_carry ^ amin_carry;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Randomized and directed checks of clock_adjust_ctrl against a seconds-of-day model.
module tb_clock_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       center = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       adjusting;
    logic [1:0] sel_field;
    logic       alarm_armed;
    logic       alarm_ringing;

    int vectors = 0;
    int miscompares = 0;

    // Model: time as seconds of day, alarm as hour/minute, plain mode flags.
    int m_t, m_ah, m_am, m_sel;
    bit m_adj, m_armed, m_ring;

    clock_adjust_ctrl #(.HR_MOD(24), .MIN_MOD(60)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1hz      (tick_1hz),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .center        (center),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .alarm_hours   (alarm_hours),
        .alarm_minutes (alarm_minutes),
        .adjusting     (adjusting),
        .sel_field     (sel_field),
        .alarm_armed   (alarm_armed),
        .alarm_ringing (alarm_ringing)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] obs();
        return {hours, minutes, seconds, alarm_hours, alarm_minutes,
                adjusting, sel_field, alarm_armed, alarm_ringing};
    endfunction

    function automatic logic [32:0] expv();
        return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 5'(m_ah), 6'(m_am),
                m_adj, 2'(m_sel), m_armed, m_ring};
    endfunction

    task automatic model_reset();
        m_t = 0; m_ah = 0; m_am = 0; m_sel = 0;
        m_adj = 0; m_armed = 0; m_ring = 0;
    endtask

    task automatic model_step(input bit c, input bit u, input bit d,
                              input bit l, input bit r, input bit tk);
        int t_new, h, mi, s, delta;
        bit was_armed, was_ring;
        if (!m_adj) begin
            was_armed = m_armed;
            was_ring  = m_ring;
            t_new = tk ? (m_t + 1) % 86400 : m_t;
            if (c) begin
                if (m_ring) m_ring = 0;
                else begin m_adj = 1; m_sel = 0; end
            end else if (u) begin
                if (m_armed) m_ring = 0;
                m_armed = !m_armed;
            end
            if (tk && !c && !u && was_armed && !was_ring && t_new == m_ah * 3600 + m_am * 60)
                m_ring = 1;
            m_t = t_new;
        end else begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (c) begin
                m_adj = 0;
                s = 0;
            end else if (l || r) begin
                if (r && !l) m_sel = (m_sel + 1) % 4;
                else if (l && !r) m_sel = (m_sel + 3) % 4;
            end else if (u != d) begin
                delta = u ? 1 : -1;
                case (m_sel)
                    0: h    = (h + 24 + delta) % 24;
                    1: mi   = (mi + 60 + delta) % 60;
                    2: m_ah = (m_ah + 24 + delta) % 24;
                    default: m_am = (m_am + 60 + delta) % 60;
                endcase
            end
            m_t = h * 3600 + mi * 60 + s;
        end
    endtask

    task automatic step(input bit c, input bit u, input bit d,
                        input bit l, input bit r, input bit tk);
        center = c; up = u; down = d; left = l; right = r; tick_1hz = tk;
        @(posedge clk);
        #1;
        center = 0; up = 0; down = 0; left = 0; right = 0; tick_1hz = 0;
        model_step(c, u, d, l, r, tk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        vectors++;
        if (obs() !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs(), 33'd0);
        end
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_tick();
        for (int i = 0; i < 61; i++) step(0, 0, 0, 0, 0, 1);
        vectors++;
        if ({hours, minutes, seconds} !== {5'd0, 6'd1, 6'd1}) begin
            miscompares++;
            $display("FAIL tick_61: got %0d:%0d:%0d expected 0:1:1", hours, minutes, seconds);
        end
    endtask

    task automatic test_rollover();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL preload_2359: got %h expected %h", obs(), expv());
        end
        for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 0, 1);
        vectors++;
        if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59}) begin
            miscompares++;
            $display("FAIL at_235959: got %0d:%0d:%0d expected 23:59:59", hours, minutes, seconds);
        end
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if ({hours, minutes, seconds} !== 17'd0) begin
            miscompares++;
            $display("FAIL day_rollover: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
        end
    endtask

    task automatic test_adjust_basic();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if ({adjusting, sel_field} !== 3'b100) begin
            miscompares++;
            $display("FAIL enter_adjust: got %b expected 100", {adjusting, sel_field});
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (sel_field !== 2'd1) begin
            miscompares++;
            $display("FAIL sel_right: got %0d expected 1", sel_field);
        end
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        vectors++;
        if (seconds !== 6'd5) begin
            miscompares++;
            $display("FAIL frozen_seconds: got %0d expected 5", seconds);
        end
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if ({adjusting, hours, minutes, seconds} !== {1'b0, 5'd3, 6'd59, 6'd0}) begin
            miscompares++;
            $display("FAIL exit_0359: got adj=%0d %0d:%0d:%0d expected adj=0 3:59:0",
                     adjusting, hours, minutes, seconds);
        end
    endtask

    task automatic test_adjust_wrap();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        vectors++;
        if (sel_field !== 2'd3) begin
            miscompares++;
            $display("FAIL sel_left_wrap: got %0d expected 3", sel_field);
        end
        step(0, 0, 1, 0, 0, 0);
        vectors++;
        if (alarm_minutes !== 6'd59) begin
            miscompares++;
            $display("FAIL amin_down_wrap: got %0d expected 59", alarm_minutes);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        vectors++;
        if (alarm_hours !== 5'd0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL ahr_up_wrap: got %h expected %h", obs(), expv());
        end
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alarm();
        bit early;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs() !== {5'd0, 6'd0, 6'd0, 5'd0, 6'd2, 1'b0, 2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL alarm_setup: got %h expected alarm 00:02 armed at 00:00:00", obs());
        end
        early = 0;
        for (int i = 0; i < 119; i++) begin
            step(0, 0, 0, 0, 0, 1);
            if (alarm_ringing) early = 1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("FAIL alarm_early: got ringing before 00:02:00 expected quiet");
        end
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if ({alarm_ringing, hours, minutes, seconds} !== {1'b1, 5'd0, 6'd2, 6'd0}) begin
            miscompares++;
            $display("FAIL alarm_rise: got ring=%0d %0d:%0d:%0d expected ring=1 0:2:0",
                     alarm_ringing, hours, minutes, seconds);
        end
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if ({alarm_ringing, adjusting, alarm_armed} !== 3'b001) begin
            miscompares++;
            $display("FAIL alarm_clear: got ring/adj/armed=%b expected 001",
                     {alarm_ringing, adjusting, alarm_armed});
        end
    endtask

    task automatic test_simultaneous();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        vectors++;
        if (obs() !== expv() || adjusting !== 1'b0) begin
            miscompares++;
            $display("FAIL center_up_adjust: got %h expected %h", obs(), expv());
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        vectors++;
        if (sel_field !== 2'd1) begin
            miscompares++;
            $display("FAIL left_right_hold: got %0d expected 1", sel_field);
        end
        step(0, 1, 1, 0, 0, 0);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL up_down_hold: got %h expected %h", obs(), expv());
        end
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        if (m_adj) step(1, 0, 0, 0, 0, 0);
        if (!m_armed) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        if (m_adj) step(0, 1, 0, 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs() !== 33'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs(), 33'd0);
        end
        #13 rst = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if (obs() !== expv()) begin
            miscompares++;
            $display("FAIL after_reset_tick: got %h expected %h", obs(), expv());
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_rollover();
        test_adjust_basic();
        test_adjust_wrap();
        test_alarm();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
